// File: rtl/parc_core_reorder_buffer.sv
// Reorder buffer for the 5-stage PARC pipeline: allocates slots in decode, completes them on
// writeback, retires them in program order and squashes speculative slots on a misprediction.
module parc_core_reorder_buffer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rob_alloc_req_val,
  output logic       rob_alloc_req_rdy,
  input  logic [4:0] rob_alloc_req_preg,
  input  logic       rob_alloc_req_spec,
  output logic [4:0] rob_alloc_resp_slot,
  input  logic       rob_fill_val,
  input  logic [4:0] rob_fill_slot,
  input  logic       rob_branch_res_val,
  input  logic       rob_branch_res_taken,
  output logic       rob_commit_wen,
  output logic [4:0] rob_commit_slot,
  output logic [4:0] rob_commit_rf_waddr
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] pending_q, pending_d;
  logic [DEPTH-1:0] spec_q, spec_d;
  logic [4:0]       preg_q [DEPTH];
  logic [4:0]       preg_d [DEPTH];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [PtrW-1:0]  spec_start_q, spec_start_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [CntW-1:0]  spec_cnt_q, spec_cnt_d;

  logic            alloc;
  logic            commit;
  logic            squash;
  logic            clear_spec;
  logic            fill_hit;
  logic [PtrW-1:0] fill_idx;

  always_comb begin
    rob_alloc_req_rdy   = (count_q != Full) && !rob_branch_res_val;
    alloc               = rob_alloc_req_val && rob_alloc_req_rdy;
    commit              = valid_q[head_q] && !pending_q[head_q] && !spec_q[head_q];
    // A taken resolution with nothing speculative must leave tail alone.
    squash              = rob_branch_res_val && rob_branch_res_taken && (spec_cnt_q != '0);
    clear_spec          = rob_branch_res_val && !rob_branch_res_taken;
    fill_idx            = rob_fill_slot[PtrW-1:0];
    fill_hit            = rob_fill_val && (32'(rob_fill_slot) < DEPTH) && valid_q[fill_idx];

    rob_alloc_resp_slot = 5'(tail_q);
    rob_commit_wen      = commit;
    rob_commit_slot     = 5'(head_q);
    rob_commit_rf_waddr = preg_q[head_q];
  end

  always_comb begin
    valid_d      = valid_q;
    pending_d    = pending_q;
    spec_d       = spec_q;
    preg_d       = preg_q;
    head_d       = head_q;
    tail_d       = tail_q;
    spec_start_d = spec_start_q;
    spec_cnt_d   = spec_cnt_q;

    if (fill_hit) pending_d[fill_idx] = 1'b0;

    if (commit) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PtrW'(1);
    end

    // Alloc and resolution are mutually exclusive: rdy is low while res_val is high.
    if (alloc) begin
      valid_d[tail_q]   = 1'b1;
      pending_d[tail_q] = 1'b1;
      spec_d[tail_q]    = rob_alloc_req_spec;
      preg_d[tail_q]    = rob_alloc_req_preg;
      tail_d            = tail_q + PtrW'(1);
      if (rob_alloc_req_spec) begin
        if (spec_cnt_q == '0) spec_start_d = tail_q;
        spec_cnt_d = spec_cnt_q + CntW'(1);
      end
    end

    if (clear_spec) begin
      spec_d     = '0;
      spec_cnt_d = '0;
    end

    if (squash) begin
      valid_d    = valid_d & ~spec_q;
      spec_d     = '0;
      tail_d     = spec_start_q;
      spec_cnt_d = '0;
    end

    if (squash) count_d = count_q - spec_cnt_q - CntW'(commit);
    else        count_d = count_q + CntW'(alloc) - CntW'(commit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      pending_q    <= '0;
      spec_q       <= '0;
      preg_q       <= '{default: '0};
      head_q       <= '0;
      tail_q       <= '0;
      spec_start_q <= '0;
      count_q      <= '0;
      spec_cnt_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      pending_q    <= pending_d;
      spec_q       <= spec_d;
      preg_q       <= preg_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      spec_start_q <= spec_start_d;
      count_q      <= count_d;
      spec_cnt_q   <= spec_cnt_d;
    end
  end

endmodule

// File: tb/tb_parc_core_reorder_buffer.sv
// Scoreboard bench for parc_core_reorder_buffer: expected retirements are queued by the
// stimulus and checked by an independent commit monitor.
module tb_parc_core_reorder_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rob_alloc_req_val = 1'b0;
  logic       rob_alloc_req_rdy;
  logic [4:0] rob_alloc_req_preg = '0;
  logic       rob_alloc_req_spec = 1'b0;
  logic [4:0] rob_alloc_resp_slot;
  logic       rob_fill_val = 1'b0;
  logic [4:0] rob_fill_slot = '0;
  logic       rob_branch_res_val = 1'b0;
  logic       rob_branch_res_taken = 1'b0;
  logic       rob_commit_wen;
  logic [4:0] rob_commit_slot;
  logic [4:0] rob_commit_rf_waddr;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];  // {slot, waddr}

  parc_core_reorder_buffer #(.DEPTH(16)) dut (
    .clk                  (clk),
    .reset                (reset),
    .rob_alloc_req_val    (rob_alloc_req_val),
    .rob_alloc_req_rdy    (rob_alloc_req_rdy),
    .rob_alloc_req_preg   (rob_alloc_req_preg),
    .rob_alloc_req_spec   (rob_alloc_req_spec),
    .rob_alloc_resp_slot  (rob_alloc_resp_slot),
    .rob_fill_val         (rob_fill_val),
    .rob_fill_slot        (rob_fill_slot),
    .rob_branch_res_val   (rob_branch_res_val),
    .rob_branch_res_taken (rob_branch_res_taken),
    .rob_commit_wen       (rob_commit_wen),
    .rob_commit_slot      (rob_commit_slot),
    .rob_commit_rf_waddr  (rob_commit_rf_waddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Commit monitor: every retirement must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && rob_commit_wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got slot %0d waddr %0d expected no commit",
                 rob_commit_slot, rob_commit_rf_waddr);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({rob_commit_slot, rob_commit_rf_waddr} !== e) begin
          errors++;
          $display("FAIL commit: got slot %0d waddr %0d expected slot %0d waddr %0d",
                   rob_commit_slot, rob_commit_rf_waddr, e[9:5], e[4:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    check("drain_before_reset", exp_q.size(), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic alloc(input int preg, input bit spec, input int exp_slot);
    rob_alloc_req_val  = 1'b1;
    rob_alloc_req_preg = 5'(preg);
    rob_alloc_req_spec = spec;
    #1;
    check("alloc_rdy", int'(rob_alloc_req_rdy), 1);
    check("alloc_slot", int'(rob_alloc_resp_slot), exp_slot);
    @(posedge clk);
    #1;
    rob_alloc_req_val  = 1'b0;
    rob_alloc_req_spec = 1'b0;
  endtask

  task automatic fill(input int slot);
    rob_fill_val  = 1'b1;
    rob_fill_slot = 5'(slot);
    step();
    rob_fill_val  = 1'b0;
  endtask

  task automatic expect_commit(input int slot, input int waddr);
    exp_q.push_back({5'(slot), 5'(waddr)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    check("reset_rdy", int'(rob_alloc_req_rdy), 1);
    check("reset_resp_slot", int'(rob_alloc_resp_slot), 0);
    check("reset_wen", int'(rob_commit_wen), 0);
    check("reset_commit_slot", int'(rob_commit_slot), 0);
    check("reset_waddr", int'(rob_commit_rf_waddr), 0);
    step();
    reset = 1'b0;

    // In-order commit with out-of-order fills; slot 2 never filled until the end.
    alloc(1, 0, 0);
    alloc(2, 0, 1);
    alloc(3, 0, 2);
    fill(1);
    idle(1);
    expect_commit(0, 1);
    expect_commit(1, 2);
    fill(0);
    idle(4);
    check("pending_slot2_holds", exp_q.size(), 0);
    expect_commit(2, 3);
    fill(2);
    idle(2);

    // Full buffer, stalled request, wrap-around.
    do_reset();
    for (int i = 0; i < 16; i++) alloc(i, 0, i);
    rob_alloc_req_val  = 1'b1;
    rob_alloc_req_preg = 5'd31;
    #1;
    check("full_rdy", int'(rob_alloc_req_rdy), 0);
    step();
    rob_alloc_req_val = 1'b0;
    check("full_tail_held", int'(rob_alloc_resp_slot), 0);
    expect_commit(0, 0);
    fill(0);
    check("commit_no_bypass_rdy", int'(rob_alloc_req_rdy), 0);
    step();
    check("after_commit_rdy", int'(rob_alloc_req_rdy), 1);
    alloc(20, 0, 0);
    idle(2);

    // Correct prediction releases speculative slots.
    do_reset();
    alloc(5, 0, 0);
    alloc(6, 1, 1);
    alloc(7, 1, 2);
    expect_commit(0, 5);
    fill(0);
    fill(1);
    fill(2);
    idle(3);
    check("spec_held", exp_q.size(), 0);
    expect_commit(1, 6);
    expect_commit(2, 7);
    rob_branch_res_val   = 1'b1;
    rob_branch_res_taken = 1'b0;
    #1;
    check("resolve_rdy", int'(rob_alloc_req_rdy), 0);
    step();
    rob_branch_res_val = 1'b0;
    idle(3);
    check("nt_tail", int'(rob_alloc_resp_slot), 3);

    // Misprediction squashes slots 1 and 2; same-cycle fill to slot 2 ignored.
    do_reset();
    alloc(5, 0, 0);
    alloc(6, 1, 1);
    alloc(7, 1, 2);
    fill(1);
    rob_branch_res_val   = 1'b1;
    rob_branch_res_taken = 1'b1;
    rob_fill_val         = 1'b1;
    rob_fill_slot        = 5'd2;
    step();
    rob_branch_res_val   = 1'b0;
    rob_branch_res_taken = 1'b0;
    rob_fill_val         = 1'b0;
    check("squash_tail", int'(rob_alloc_resp_slot), 1);
    fill(2);
    idle(2);
    // count is 1 after the squash, so exactly 15 more fit.
    for (int i = 1; i < 16; i++) alloc(i, 0, i);
    #1;
    check("squash_count_full", int'(rob_alloc_req_rdy), 0);
    expect_commit(0, 5);
    fill(0);
    idle(3);

    // Misprediction in the same cycle as the commit of slot 0.
    do_reset();
    alloc(5, 0, 0);
    alloc(6, 1, 1);
    alloc(7, 1, 2);
    expect_commit(0, 5);
    fill(0);
    rob_branch_res_val   = 1'b1;
    rob_branch_res_taken = 1'b1;
    step();
    rob_branch_res_val   = 1'b0;
    rob_branch_res_taken = 1'b0;
    check("squash_commit_tail", int'(rob_alloc_resp_slot), 1);
    alloc(9, 0, 1);
    for (int k = 0; k < 15; k++) alloc(k, 0, (2 + k) % 16);
    #1;
    check("squash_commit_count", int'(rob_alloc_req_rdy), 0);
    expect_commit(1, 9);
    fill(1);
    idle(3);

    // Asynchronous reset mid-stream with count 5 and a commit pending.
    do_reset();
    for (int i = 0; i < 6; i++) alloc(10 + i, 0, i);
    expect_commit(0, 10);
    fill(0);
    idle(1);
    fill(1);
    check("pre_reset_wen", int'(rob_commit_wen), 1);
    check("pre_reset_slot", int'(rob_commit_slot), 1);
    #1;
    reset = 1'b1;
    #1;
    check("async_wen", int'(rob_commit_wen), 0);
    check("async_rdy", int'(rob_alloc_req_rdy), 1);
    check("async_resp_slot", int'(rob_alloc_resp_slot), 0);
    check("async_commit_slot", int'(rob_commit_slot), 0);
    check("async_waddr", int'(rob_commit_rf_waddr), 0);
    step();
    reset = 1'b0;
    idle(2);
    check("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
